// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
//   arbState : FSM encoding (IDLE, BUSY_I, BUSY_D, RESP)
//   arbPort  : requester identity used for round-robin and response routing
//   DEFAULT_TIMEOUT : BUSY cycles allowed without bus_ack before forced completion
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arbPort;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating 8-bit cycle counter guarding a bus transaction.
//   clk, rst  : clock, async active-low reset
//   clear     : zero the count (new transaction granted)
//   enable    : count this cycle (transaction in flight)
//   limit     : number of enabled cycles allowed (1..255)
//   expired   : high during the enabled cycle that uses up the limit
module bus_timeout_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of cycles already spent, so the current cycle is
  // number count+1; expire when that reaches the limit.
  assign expired = enable && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch (I) and mem-stage (D) ports.
// One transaction at a time, round-robin on ties, one-cycle ready pulses,
// timeout-forced completion with err.
//   clk, rst                         : clock, async active-low reset
//   i_req/i_addr -> i_rdata/i_ready  : instruction read port
//   d_req/d_we/d_be/d_addr/d_wdata
//                -> d_rdata/d_ready  : data read/write port
//   err                              : with a ready pulse, transaction timed out
//   stall_f, stall_m                 : port waiting (to hazard unit)
//   bus_*                            : memory bus master side
//
// state  | meaning
// IDLE   | no transaction; grant on any request
// BUSY_I | instruction read on the bus, waiting for ack or timeout
// BUSY_D | data read/write on the bus, waiting for ack or timeout
// RESP   | one-cycle ready (and err) to the granted port; never grants
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            err,
  output logic            stall_f,
  output logic            stall_m,
  output logic            bus_req,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_be,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack
);

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

  arbState state, nextState;
  arbPort  lastGrant;
  logic    grantI, grantD, busy, expired, respErr;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  bus_timeout_ctr uTimeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grantI | grantD),
    .enable  (busy),
    .limit   (TimeoutLimit),
    .expired (expired)
  );

  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (d_req && (!i_req || (lastGrant == PORT_I))) begin
          grantD    = 1'b1;
          nextState = BUSY_D;
        end else if (i_req) begin
          grantI    = 1'b1;
          nextState = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus_ack || expired) nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastGrant <= PORT_I;
      respErr   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= nextState;
      if (grantD) begin
        bus_addr  <= d_addr;
        bus_we    <= d_we;
        bus_be    <= d_be;
        bus_wdata <= d_wdata;
        lastGrant <= PORT_D;
      end else if (grantI) begin
        bus_addr  <= i_addr;
        bus_we    <= 1'b0;
        bus_be    <= '1;
        bus_wdata <= '0;
        lastGrant <= PORT_I;
      end
      if (busy) begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          respErr <= 1'b0;
          if (state == BUSY_I)  i_rdata <= bus_rdata;
          else if (!bus_we)     d_rdata <= bus_rdata;
        end else if (expired) begin
          respErr <= 1'b1;
        end
      end
    end
  end

  assign bus_req = busy;
  assign i_ready = (state == RESP) && (lastGrant == PORT_I);
  assign d_ready = (state == RESP) && (lastGrant == PORT_D);
  assign err     = (state == RESP) && respErr;
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [31:0]   i_addr = '0;
  logic [31:0]   i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = '0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          err;
  logic          stall_f;
  logic          stall_m;
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata = '0;
  logic          bus_ack = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .stall_f(stall_f), .stall_m(stall_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    bit          isD;
    logic [31:0] rdata;
    bit          err;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  logic [31:0] lastDRdata = '0;

  // Bus responder: ack in the (ackDelay+1)-th cycle of bus_req, data = base + ack index.
  bit          ackEnable = 1'b0;
  int          ackDelay  = 0;
  logic [31:0] ackBase   = '0;
  int          ackCount  = 0;
  int          reqCycles = 0;

  always @(negedge clk) begin
    if (bus_req) begin
      if (ackEnable && (reqCycles == ackDelay)) begin
        bus_ack   = 1'b1;
        bus_rdata = ackBase + 32'(ackCount);
        ackCount++;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
      end
      reqCycles++;
    end else begin
      reqCycles = 0;
      bus_ack   = 1'b0;
      bus_rdata = 32'hFFFF_FFFF;
    end
  end

  task automatic setBus(input bit en, input int dly, input logic [31:0] base);
    ackEnable = en;
    ackDelay  = dly;
    ackBase   = base;
    ackCount  = 0;
  endtask

  task automatic waitReady(input int maxCyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && (cyc < maxCyc)) begin
      @(negedge clk);
      cyc++;
      if (i_ready || d_ready) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, i_ready, d_ready, err, bus_we} !== 5'b0 || i_rdata !== 32'h0 ||
        d_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b rdy=%b/%b err=%b addr=%h exp all zero",
               bus_req, i_ready, d_ready, err, bus_addr);
    end
    rst = 1'b1;
    setBus(1'b0, 0, 32'h0);
    d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF; d_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++; $display("FAIL reset_busy_d bus_req got=%b exp=1", bus_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0) begin
      failures++; $display("FAIL reset_async_drop bus_req got=%b exp=0", bus_req);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (d_ready || i_ready || bus_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL reset_no_ready got activity=%b exp=0", seen);
    end
    checks++;
    if (dut.state !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", dut.state);
    end
  endtask

  task automatic test_single_i_read();
    expT e;
    setBus(1'b1, 0, 32'h2408_0001);
    i_addr = 32'hBFC0_0000; i_req = 1'b1;
    expQ.push_back('{isD: 1'b0, rdata: 32'h2408_0001, err: 1'b0});
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0000 || bus_we !== 1'b0 || bus_be !== 4'hF) begin
      failures++;
      $display("FAIL i_bus_fields got req=%b addr=%h we=%b be=%h exp 1 bfc00000 0 f",
               bus_req, bus_addr, bus_we, bus_be);
    end
    checks++;
    if (stall_f !== 1'b1) begin
      failures++; $display("FAIL i_stall_busy got=%b exp=1", stall_f);
    end
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0) begin
      failures++; $display("FAIL i_latency got i_ready=%b d_ready=%b exp 1 0", i_ready, d_ready);
    end
    e = expQ.pop_front();
    checks++;
    if (i_rdata !== e.rdata) begin
      failures++; $display("FAIL i_rdata got=%h exp=%h", i_rdata, e.rdata);
    end
    checks++;
    if (err !== e.err) begin
      failures++; $display("FAIL i_err got=%b exp=%b", err, e.err);
    end
    checks++;
    if (stall_f !== 1'b0) begin
      failures++; $display("FAIL i_stall_ready got=%b exp=0", stall_f);
    end
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL i_pulse_width got i_ready=%b bus_req=%b exp 0 0", i_ready, bus_req);
    end
  endtask

  task automatic test_d_write();
    expT e;
    int  cyc;
    bit  ok;
    setBus(1'b1, 2, 32'h1234_5678);
    d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; d_we = 1'b1; d_req = 1'b1;
    expQ.push_back('{isD: 1'b1, rdata: lastDRdata, err: 1'b0});
    @(negedge clk);
    checks++;
    if (bus_we !== 1'b1 || bus_be !== 4'b0011 || bus_addr !== 32'h100 || bus_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL d_bus_fields got we=%b be=%b addr=%h wdata=%h exp 1 0011 100 deadbeef",
               bus_we, bus_be, bus_addr, bus_wdata);
    end
    waitReady(10, cyc, ok);
    checks++;
    if (!ok || d_ready !== 1'b1 || cyc != 3) begin
      failures++; $display("FAIL d_write_ready got ok=%b d_ready=%b cyc=%0d exp 1 1 3", ok, d_ready, cyc);
    end
    e = expQ.pop_front();
    checks++;
    if (d_rdata !== e.rdata) begin
      failures++; $display("FAIL d_write_rdata got=%h exp=%h", d_rdata, e.rdata);
    end
    checks++;
    if (err !== e.err) begin
      failures++; $display("FAIL d_write_err got=%b exp=%b", err, e.err);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    expT e;
    int  cyc;
    bit  ok;
    bit  nextIsD;
    rst = 1'b0;
    expQ.delete();
    i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; d_be = 4'hF;
    i_req = 1'b1; d_req = 1'b1;
    setBus(1'b1, 0, 32'hA000_0000);
    repeat (2) @(negedge clk);
    lastDRdata = '0;
    nextIsD = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expQ.push_back('{isD: nextIsD, rdata: 32'hA000_0000 + 32'(k), err: 1'b0});
      nextIsD = !nextIsD;
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      waitReady(8, cyc, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok || d_ready !== e.isD || i_ready !== !e.isD) begin
        failures++;
        $display("FAIL rr_grant_%0d got d_ready=%b i_ready=%b exp d_ready=%b", k, d_ready, i_ready, e.isD);
      end
      checks++;
      if ((e.isD ? d_rdata : i_rdata) !== e.rdata) begin
        failures++;
        $display("FAIL rr_rdata_%0d got=%h exp=%h", k, (e.isD ? d_rdata : i_rdata), e.rdata);
      end
      checks++;
      if (cyc != ((k == 0) ? 2 : 3)) begin
        failures++; $display("FAIL rr_interval_%0d got=%0d exp=%0d", k, cyc, ((k == 0) ? 2 : 3));
      end
      if (e.isD) lastDRdata = e.rdata;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    expT e;
    int  cyc;
    bit  ok;
    int  reqHigh;
    setBus(1'b0, 0, 32'h0);
    d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    expQ.push_back('{isD: 1'b1, rdata: lastDRdata, err: 1'b1});
    ok = 1'b0; reqHigh = 0;
    for (int n = 0; (n < 12) && !ok; n++) begin
      @(negedge clk);
      if (bus_req) reqHigh++;
      if (d_ready || i_ready) ok = 1'b1;
    end
    e = expQ.pop_front();
    checks++;
    if (reqHigh != TO) begin
      failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", reqHigh, TO);
    end
    checks++;
    if (!ok || d_ready !== 1'b1 || err !== e.err) begin
      failures++; $display("FAIL to_ready_err got ok=%b d_ready=%b err=%b exp 1 1 1", ok, d_ready, err);
    end
    checks++;
    if (d_rdata !== e.rdata) begin
      failures++; $display("FAIL to_rdata got=%h exp=%h", d_rdata, e.rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    setBus(1'b1, 0, 32'h55AA_55AA);
    i_addr = 32'h800; i_req = 1'b1;
    expQ.push_back('{isD: 1'b0, rdata: 32'h55AA_55AA, err: 1'b0});
    waitReady(6, cyc, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || i_ready !== 1'b1 || err !== e.err || i_rdata !== e.rdata) begin
      failures++;
      $display("FAIL to_recover got ok=%b i_ready=%b err=%b rdata=%h exp 1 1 0 %h",
               ok, i_ready, err, i_rdata, e.rdata);
    end
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    expT e;
    int  cyc;
    bit  ok;
    bit  seen;
    setBus(1'b1, 1, 32'h0BAD_F00D);
    i_addr = 32'h400; i_req = 1'b1;
    expQ.push_back('{isD: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
    @(negedge clk);
    i_req = 1'b0; i_addr = 32'hFFFF_0000;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin
      failures++; $display("FAIL wd_latched got req=%b addr=%h exp 1 400", bus_req, bus_addr);
    end
    waitReady(6, cyc, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || i_ready !== 1'b1 || cyc != 1) begin
      failures++; $display("FAIL wd_ready got ok=%b i_ready=%b cyc=%0d exp 1 1 1", ok, i_ready, cyc);
    end
    checks++;
    if (i_rdata !== e.rdata || err !== e.err) begin
      failures++; $display("FAIL wd_rdata got=%h err=%b exp=%h 0", i_rdata, err, e.rdata);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_req || i_ready || d_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL wd_no_regrant got activity=%b exp=0", seen);
    end
    setBus(1'b1, TO - 1, 32'h1357_2468);
    d_addr = 32'h500; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    expQ.push_back('{isD: 1'b1, rdata: 32'h1357_2468, err: 1'b0});
    waitReady(10, cyc, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || d_ready !== 1'b1 || cyc != TO + 1) begin
      failures++; $display("FAIL coinc_ready got ok=%b d_ready=%b cyc=%0d exp 1 1 %0d", ok, d_ready, cyc, TO + 1);
    end
    checks++;
    if (err !== e.err || d_rdata !== e.rdata) begin
      failures++; $display("FAIL coinc_ack_wins got err=%b rdata=%h exp 0 %h", err, d_rdata, e.rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_i_read();
    test_d_write();
    test_round_robin();
    test_timeout();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
